// File: rtl/cap_sense_pkg.sv
// Shared types and sizing for the capacitive pad scanner.
// The readings bus is N_SENSORS slices of COUNT_W bits, pad 0 in the low slice.
package cap_sense_pkg;

    typedef enum logic [1:0] {
        DISCHARGE,
        CHARGE,
        LATCH
    } scan_state_t;

    localparam int N_SENSORS = 9;
    localparam int COUNT_W   = 32;

    function automatic int slice_base(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/cap_channel_timer.sv
// One pad: 2-flop synchronizer, done flag, saturating rise-time counter
// and the touch threshold compare on the value that would be published.
module cap_channel_timer #(
    parameter int TIMEOUT_CYCLES  = 50000,
    parameter int TOUCH_THRESHOLD = 2000,
    parameter int CNT_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pad_in,
    input  logic             start,
    input  logic             run,
    output logic             done_next,
    output logic [CNT_W-1:0] value,
    output logic             touch
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(TOUCH_THRESHOLD);

    logic [1:0]       sync_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pad_s;

    assign pad_s = sync_q[1];

    // The synchronizer is flushed at charge start so every count carries
    // the same +2 offset, even for a pad that never discharged.
    always_ff @(posedge clock) begin
        if (reset || start) begin
            sync_q <= '0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], pad_in};
            if (run && !done_q) begin
                if (pad_s) begin
                    done_q <= 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign done_next = done_q | pad_s;
    assign value     = done_q ? cnt_q : CNT_MAX;
    assign touch     = (value >= THRESH);

endmodule

// File: rtl/cap_touch_scanner.sv
// Discharge / charge / latch scan of the shared RC drive, timing each
// pad's rise and publishing one frame of counts plus touch flags.
module cap_touch_scanner #(
    parameter int N_SENSORS        = cap_sense_pkg::N_SENSORS,
    parameter int COUNT_W          = cap_sense_pkg::COUNT_W,
    parameter int DISCHARGE_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES   = 50000,
    parameter int TOUCH_THRESHOLD  = 2000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_SENSORS-1:0]         capacitive_sensors_in,
    output logic                         capacitive_sensors_out,
    output logic [N_SENSORS*COUNT_W-1:0] capacitive_sensor_readings,
    output logic [N_SENSORS-1:0]         touched,
    output logic                         readings_valid
);

    import cap_sense_pkg::*;

    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PH_MAX = (DISCHARGE_CYCLES > TIMEOUT_CYCLES) ?
                            DISCHARGE_CYCLES : TIMEOUT_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0] DIS_LAST = PH_W'(DISCHARGE_CYCLES - 1);
    localparam logic [PH_W-1:0] CHG_LAST = PH_W'(TIMEOUT_CYCLES - 1);

    scan_state_t          state;
    logic [PH_W-1:0]      phase;
    logic                 start;
    logic                 run;
    logic                 all_done;
    logic [N_SENSORS-1:0] done_next;
    logic [N_SENSORS-1:0] touch_w;
    logic [CNT_W-1:0]     value_w [N_SENSORS];

    assign start    = (state == DISCHARGE) && (phase == DIS_LAST);
    assign run      = (state == CHARGE);
    assign all_done = &done_next;

    for (genvar g = 0; g < N_SENSORS; g++) begin : g_chan
        cap_channel_timer #(
            .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
            .TOUCH_THRESHOLD (TOUCH_THRESHOLD),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .pad_in    (capacitive_sensors_in[g]),
            .start     (start),
            .run       (run),
            .done_next (done_next[g]),
            .value     (value_w[g]),
            .touch     (touch_w[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                      <= DISCHARGE;
            phase                      <= '0;
            capacitive_sensors_out     <= 1'b0;
            capacitive_sensor_readings <= '0;
            touched                    <= '0;
            readings_valid             <= 1'b0;
        end else begin
            readings_valid <= 1'b0;
            unique case (state)
                DISCHARGE: begin
                    if (phase == DIS_LAST) begin
                        state                  <= CHARGE;
                        phase                  <= '0;
                        capacitive_sensors_out <= 1'b1;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                CHARGE: begin
                    // all-done wins a tie with the timeout; values match
                    if (all_done || phase == CHG_LAST) begin
                        state                  <= LATCH;
                        phase                  <= '0;
                        capacitive_sensors_out <= 1'b0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                LATCH: begin
                    state          <= DISCHARGE;
                    readings_valid <= 1'b1;
                    touched        <= touch_w;
                    for (int i = 0; i < N_SENSORS; i++) begin
                        capacitive_sensor_readings[slice_base(i, COUNT_W) +: COUNT_W]
                            <= COUNT_W'(value_w[i]);
                    end
                end
                default: begin
                    state                  <= DISCHARGE;
                    phase                  <= '0;
                    capacitive_sensors_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
